// File: rtl/fifo_nonlookahead_to_lookahead_if.sv
`default_nettype none
//==============================================================================
// Module   : fifo_nonlookahead_to_lookahead_if
// Brief    : Upstream (non-lookahead) and downstream (lookahead) read-port
//            bundle for the FWFT adapter.
// Revision : 1.0 - initial release
//==============================================================================
interface fifo_nonlookahead_to_lookahead_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  _empty;
    logic                  _rd;
    logic [DATA_WIDTH-1:0] _dout;
    logic                  empty;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;

    // slave = the adapter, master = the environment around it
    modport slave (
        input  _empty, _dout, rd,
        output _rd, empty, dout
    );

    modport master (
        output _empty, _dout, rd,
        input  _rd, empty, dout
    );
endinterface
`default_nettype wire

// File: rtl/fifo_nonlookahead_to_lookahead.sv
`default_nettype none
//==============================================================================
// Module   : fifo_nonlookahead_to_lookahead
// Brief    : Turns a registered-output FIFO read port into a first-word-fall-
//            through port via a small prefetch buffer. Define
//            PRGA_FIFO_N2L_REG_RD_EN for a 3-entry buffer with no rd->_rd path.
// Revision : 1.0 - initial release
//==============================================================================
module fifo_nonlookahead_to_lookahead #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    fifo_nonlookahead_to_lookahead_if.slave bus
);

`ifdef PRGA_FIFO_N2L_REG_RD_EN
    localparam int c_DEPTH = 3;
`else
    localparam int c_DEPTH = 2;
`endif

    logic [c_DEPTH-1:0][DATA_WIDTH-1:0] w_q;
    logic [1:0]                         r_cnt;
    logic                               r_pend;
    logic                               w_pop;
    logic [2:0]                         w_level;
    logic                               w_rd;
    logic [1:0]                         w_wr_idx;

    assign w_pop = bus.rd && (r_cnt != 2'd0);

`ifdef PRGA_FIFO_N2L_REG_RD_EN
    // Spare entry lets the fetch decision ignore this cycle's pop
    assign w_level = {1'b0, r_cnt} + {2'b00, r_pend};
`else
    assign w_level = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
`endif

    assign w_rd     = !rst && !bus._empty && (w_level < 3'(c_DEPTH));
    assign w_wr_idx = r_cnt - {1'b0, w_pop};

    assign bus._rd   = w_rd;
    assign bus.empty = (r_cnt == 2'd0);
    assign bus.dout  = w_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_pend <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
            r_pend <= w_rd;
        end
    end

    genvar g;
    generate
        for (g = 0; g < c_DEPTH; g++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_data;
            logic [DATA_WIDTH-1:0] w_next;

            if (g < c_DEPTH - 1) begin : g_shift
                assign w_next = w_q[g+1];
            end else begin : g_tail
                assign w_next = r_data;
            end

            // An arriving word lands after the shift, so it wins over w_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= '0;
                end else if (r_pend && (w_wr_idx == 2'(g))) begin
                    r_data <= bus._dout;
                end else if (w_pop) begin
                    r_data <= w_next;
                end
            end

            assign w_q[g] = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_nonlookahead_to_lookahead.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_nonlookahead_to_lookahead
// Brief    : Directed self-checking bench for the FWFT adapter with a
//            registered-output upstream FIFO model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fifo_nonlookahead_to_lookahead;

`ifdef PRGA_FIFO_N2L_REG_RD_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_nonlookahead_to_lookahead_if #(.DATA_WIDTH(DW)) bus ();

    fifo_nonlookahead_to_lookahead #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src [8];
    int up_len  = 0;
    int up_ptr  = 0;
    int fetched = 0;
    int popped  = 0;
    int total   = 0;
    int bad     = 0;

    // Upstream: non-lookahead FIFO, data registered one cycle after _rd
    assign bus._empty = (up_ptr >= up_len);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            up_ptr   <= 0;
            bus._dout <= '0;
            fetched  <= 0;
            popped   <= 0;
        end else begin
            if (bus._rd) begin
                bus._dout <= (up_ptr < 8) ? src[up_ptr] : '0;
                up_ptr   <= up_ptr + 1;
                fetched  <= fetched + 1;
            end
            if (bus.rd && !bus.empty)
                popped <= popped + 1;
        end
    end

    task automatic set_data(input bit alt);
        if (!alt) begin
            src[0] = 32'h5A; src[1] = 32'hF6; src[2] = 32'h09; src[3] = 32'hC4;
            src[4] = 32'h81; src[5] = 32'hE2; src[6] = 32'hA0; src[7] = 32'h7A;
        end else begin
            src[0] = 32'hA5; src[1] = 32'h09; src[2] = 32'hF6; src[3] = 32'h3B;
            src[4] = 32'h7E; src[5] = 32'h1D; src[6] = 32'h5F; src[7] = 32'h85;
        end
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        set_data(1'b0);
        up_len = 8;
        bus.rd = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++;
        if (bus._rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", bus._rd); end
        total++;
        if (bus.dout !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        @(posedge clk);
        #1;
        total++;
        if (bus._rd !== 1'b0) begin bad++; $display("FAIL reset_rd_held: got %b want 0", bus._rd); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_release_empty: got %b want 1", bus.empty); end
        total++;
        if (bus._rd !== 1'b1) begin bad++; $display("FAIL reset_release_rd: got %b want 1", bus._rd); end
    endtask

    // Entered right at reset release with rd=1 and upstream holding 8 words
    task automatic check_stream(input string name);
        @(negedge clk); #1;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL %s_latency_t1: empty got %b want 1", name, bus.empty); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            total++;
            if (bus.empty !== 1'b0 || bus.dout !== src[k]) begin
                bad++;
                $display("FAIL %s_word%0d: got empty=%b dout=%h want empty=0 dout=%h",
                         name, k, bus.empty, bus.dout, src[k]);
            end
        end
        @(negedge clk); #1;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL %s_drained: empty got %b want 1", name, bus.empty); end
        total++;
        if (fetched !== 8 || popped !== 8) begin
            bad++;
            $display("FAIL %s_counts: got fetched=%0d popped=%0d want 8/8", name, fetched, popped);
        end
    endtask

    task automatic test_stream;
        set_data(1'b0);
        up_len = 8;
        bus.rd = 1'b1;
        pulse_reset();
        check_stream("stream");
    endtask

    task automatic test_random;
        int k = 0;
        set_data(1'b0);
        up_len = 8;
        bus.rd = 1'b0;
        pulse_reset();
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            @(negedge clk);
            total++;
            if (fetched - popped > N) begin
                bad++;
                $display("FAIL random_overfetch: got outstanding=%0d want <=%0d", fetched - popped, N);
            end
            bus.rd = 1'($urandom % 2);
            #1;
            if (bus.rd && !bus.empty) begin
                total++;
                if (bus.dout !== src[k]) begin
                    bad++;
                    $display("FAIL random_word%0d: got %h want %h", k, bus.dout, src[k]);
                end
                k++;
            end
        end
        total++;
        if (k != 8) begin bad++; $display("FAIL random_timeout: got popped=%0d want 8", k); end
        @(negedge clk);
        bus.rd = 1'b0;
        #1;
        total++;
        if (bus.empty !== 1'b1 || fetched !== 8) begin
            bad++;
            $display("FAIL random_end: got empty=%b fetched=%0d want 1/8", bus.empty, fetched);
        end
    endtask

    task automatic test_stall;
        set_data(1'b0);
        up_len = 8;
        bus.rd = 1'b0;
        pulse_reset();
        repeat (8) @(negedge clk);
        #1;
        total++;
        if (fetched !== N) begin bad++; $display("FAIL stall_fetched: got %0d want %0d", fetched, N); end
        total++;
        if (bus._rd !== 1'b0) begin bad++; $display("FAIL stall_rd: got %b want 0", bus._rd); end
        total++;
        if (bus.empty !== 1'b0 || bus.dout !== 32'h5A) begin
            bad++;
            $display("FAIL stall_head: got empty=%b dout=%h want 0/5a", bus.empty, bus.dout);
        end
    endtask

    task automatic test_rd_when_empty;
        set_data(1'b0);
        up_len = 0;
        bus.rd = 1'b1;
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            total++;
            if (bus.empty !== 1'b1 || bus._rd !== 1'b0 || bus.dout !== 32'h0) begin
                bad++;
                $display("FAIL rd_empty_c%0d: got empty=%b _rd=%b dout=%h want 1/0/0",
                         c, bus.empty, bus._rd, bus.dout);
            end
        end
        bus.rd = 1'b0;
        up_len = 8;
        @(negedge clk); #1;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL rd_empty_refill_t1: empty got %b want 1", bus.empty); end
        @(negedge clk); #1;
        total++;
        if (bus.empty !== 1'b0 || bus.dout !== 32'h5A) begin
            bad++;
            $display("FAIL rd_empty_refill_head: got empty=%b dout=%h want 0/5a", bus.empty, bus.dout);
        end
        bus.rd = 1'b1;
        @(negedge clk); #1;
        total++;
        if (bus.empty !== 1'b0 || bus.dout !== 32'hF6) begin
            bad++;
            $display("FAIL rd_empty_refill_next: got empty=%b dout=%h want 0/f6", bus.empty, bus.dout);
        end
        bus.rd = 1'b0;
    endtask

    task automatic test_reset_mid;
        set_data(1'b0);
        up_len = 8;
        bus.rd = 1'b0;
        pulse_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.empty !== 1'b0 || bus.dout !== 32'h5A) begin
            bad++;
            $display("FAIL reset_mid_prefill: got empty=%b dout=%h want 0/5a", bus.empty, bus.dout);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.empty !== 1'b1 || bus._rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got empty=%b _rd=%b want 1/0", bus.empty, bus._rd);
        end
        set_data(1'b1);
        bus.rd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_stream("reset_mid");
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.rd = 1'b0;
        set_data(1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        test_stream();
        test_random();
        test_stall();
        test_rd_when_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
